// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared constants, field encoding and edit-FSM state type for
//                the time-of-day clock and its time-entry controller.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

    // Field widths
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Largest legal value of each field
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Encoding of the active-field indicator
    localparam int         FIELD_W    = 2;
    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    // Time-entry controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_SEC  = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    // Field indicator shown for a given state (IDLE/COMMIT show none)
    function automatic logic [1:0] state_to_field(input state_t s);
        case (s)
            ST_EDIT_HOUR: return FIELD_HOUR;
            ST_EDIT_MIN:  return FIELD_MIN;
            ST_EDIT_SEC:  return FIELD_SEC;
            default:      return FIELD_NONE;
        endcase
    endfunction

    // True for the three editing states
    function automatic logic is_edit(input state_t s);
        return (s == ST_EDIT_HOUR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
    endfunction

endpackage : clock_pkg
`default_nettype wire

// File: rtl/field_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : field_stepper
//  Description : Combinational wrap-around +1/-1 stepper for one time field,
//                plus an out-of-range clamp used when loading a fresh value.
//  Revision    : 1.0  initial release
// ============================================================================
module field_stepper #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] value,      // current staged value
    input  logic         inc,        // step up request
    input  logic         dec,        // step down request
    input  logic [W-1:0] load_val,   // raw value to be loaded
    output logic [W-1:0] step_val,   // value after the requested step
    output logic [W-1:0] clamp_val   // load_val, or 0 when it exceeds MAX
);

    localparam logic [W-1:0] C_MAX = W'(MAX);

    // Simultaneous inc and dec cancel out and leave the value unchanged
    always_comb begin
        step_val = value;
        if (inc && !dec) begin
            step_val = (value == C_MAX) ? '0 : value + W'(1);
        end else if (dec && !inc) begin
            step_val = (value == '0) ? C_MAX : value - W'(1);
        end
    end

    assign clamp_val = (load_val > C_MAX) ? '0 : load_val;

endmodule : field_stepper
`default_nettype wire

// File: rtl/time_setter.sv
`default_nettype none
// ============================================================================
//  Module      : time_setter
//  Description : Button-driven time-entry controller. Captures the running
//                time, lets the user step hour/minute/second with wrap, and
//                loads the Clock with a single set strobe on commit. An idle
//                edit is abandoned after TIMEOUT_CYCLES without a strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module time_setter
    import clock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_btn,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic [SEC_W-1:0]  sec_cur,
    input  logic [MIN_W-1:0]  min_cur,
    input  logic [HOUR_W-1:0] hour_cur,
    output logic [SEC_W-1:0]  sec_in,
    output logic [MIN_W-1:0]  min_in,
    output logic [HOUR_W-1:0] hour_in,
    output logic              set,
    output logic              editing,
    output logic [FIELD_W-1:0] field
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic [SEC_W-1:0]    w_sec_nxt;
    logic [MIN_W-1:0]    w_min_nxt;
    logic [HOUR_W-1:0]   w_hour_nxt;
    logic                w_set_nxt;
    logic                w_editing_nxt;
    logic [FIELD_W-1:0]  w_field_nxt;

    logic [SEC_W-1:0]    w_sec_step;
    logic [SEC_W-1:0]    w_sec_clamp;
    logic [MIN_W-1:0]    w_min_step;
    logic [MIN_W-1:0]    w_min_clamp;
    logic [HOUR_W-1:0]   w_hour_step;
    logic [HOUR_W-1:0]   w_hour_clamp;

    logic                w_any_btn;

    assign w_any_btn = mode_btn | inc_btn | dec_btn;

    field_stepper #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour_step (
        .value    (hour_in),
        .inc      (inc_btn),
        .dec      (dec_btn),
        .load_val (hour_cur),
        .step_val (w_hour_step),
        .clamp_val(w_hour_clamp)
    );

    field_stepper #(.W(MIN_W), .MAX(MIN_MAX)) u_min_step (
        .value    (min_in),
        .inc      (inc_btn),
        .dec      (dec_btn),
        .load_val (min_cur),
        .step_val (w_min_step),
        .clamp_val(w_min_clamp)
    );

    field_stepper #(.W(SEC_W), .MAX(SEC_MAX)) u_sec_step (
        .value    (sec_in),
        .inc      (inc_btn),
        .dec      (dec_btn),
        .load_val (sec_cur),
        .step_val (w_sec_step),
        .clamp_val(w_sec_clamp)
    );

    // Next-state, staging, timeout and output decode; mode beats inc/dec
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sec_nxt   = sec_in;
        w_min_nxt   = min_in;
        w_hour_nxt  = hour_in;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (mode_btn) begin
                    w_hour_nxt  = w_hour_clamp;
                    w_min_nxt   = w_min_clamp;
                    w_sec_nxt   = w_sec_clamp;
                    w_state_nxt = ST_EDIT_HOUR;
                end
            end

            ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_SEC: begin
                if (w_any_btn) begin
                    w_cnt_nxt = '0;
                    if (mode_btn) begin
                        case (r_state)
                            ST_EDIT_HOUR: w_state_nxt = ST_EDIT_MIN;
                            ST_EDIT_MIN:  w_state_nxt = ST_EDIT_SEC;
                            default:      w_state_nxt = ST_COMMIT;
                        endcase
                    end else begin
                        case (r_state)
                            ST_EDIT_HOUR: w_hour_nxt = w_hour_step;
                            ST_EDIT_MIN:  w_min_nxt  = w_min_step;
                            default:      w_sec_nxt  = w_sec_step;
                        endcase
                    end
                end else if (r_cnt == CNT_LAST) begin
                    // Abandon the edit; staged values are left as they are
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_COMMIT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_set_nxt     = (w_state_nxt == ST_COMMIT);
        w_editing_nxt = is_edit(w_state_nxt);
        w_field_nxt   = state_to_field(w_state_nxt);
    end

    // State, counter and all outputs registered; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            sec_in  <= '0;
            min_in  <= '0;
            hour_in <= '0;
            set     <= 1'b0;
            editing <= 1'b0;
            field   <= FIELD_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            sec_in  <= w_sec_nxt;
            min_in  <= w_min_nxt;
            hour_in <= w_hour_nxt;
            set     <= w_set_nxt;
            editing <= w_editing_nxt;
            field   <= w_field_nxt;
        end
    end

endmodule : time_setter
`default_nettype wire

// File: tb/tb_time_setter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_setter
//  Description : Directed, table-driven self-checking bench for time_setter
//                (TIMEOUT_CYCLES = 16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_time_setter;

    logic       clk;
    logic       reset;
    logic       mode_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic [5:0] sec_cur;
    logic [5:0] min_cur;
    logic [4:0] hour_cur;
    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic [4:0] hour_in;
    logic       set;
    logic       editing;
    logic [1:0] field;

    int n_tests = 0;
    int n_fail  = 0;

    time_setter #(.TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .mode_btn(mode_btn),
        .inc_btn (inc_btn),
        .dec_btn (dec_btn),
        .sec_cur (sec_cur),
        .min_cur (min_cur),
        .hour_cur(hour_cur),
        .sec_in  (sec_in),
        .min_in  (min_in),
        .hour_in (hour_in),
        .set     (set),
        .editing (editing),
        .field   (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       m, i, d;
        logic [5:0] sc, mc;
        logic [4:0] hc;
        logic [5:0] es, em;
        logic [4:0] eh;
        logic       eset, eed;
        logic [1:0] ef;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(logic m, logic i, logic d,
                                int sc, int mc, int hc,
                                int es, int em, int eh,
                                logic eset, logic eed, int ef);
        vec_t v;
        v.m = m; v.i = i; v.d = d;
        v.sc = 6'(sc); v.mc = 6'(mc); v.hc = 5'(hc);
        v.es = 6'(es); v.em = 6'(em); v.eh = 5'(eh);
        v.eset = eset; v.eed = eed; v.ef = 2'(ef);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input int es, input int em, input int eh,
                             input int eset, input int eed, input int ef);
        chk({tag, ".sec_in"},  int'(sec_in),  es);
        chk({tag, ".min_in"},  int'(min_in),  em);
        chk({tag, ".hour_in"}, int'(hour_in), eh);
        chk({tag, ".set"},     int'(set),     eset);
        chk({tag, ".editing"}, int'(editing), eed);
        chk({tag, ".field"},   int'(field),   ef);
    endtask

    // Drive buttons for one cycle, then sample 1 time unit after the edge
    task automatic step(input logic m, input logic i, input logic d);
        mode_btn = m; inc_btn = i; dec_btn = d;
        @(posedge clk);
        #1;
        mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    endtask

    task automatic set_cur(input int h, input int mi, input int s);
        hour_cur = 5'(h); min_cur = 6'(mi); sec_cur = 6'(s);
    endtask

    initial begin
        reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
        set_cur(1, 58, 30);

        //            m  i  d   sc  mc  hc    es  em  eh  set ed fld
        // IDLE ignores inc/dec
        vecs[0]  = mk(0, 1, 0,  30, 58,  1,    0,  0,  0,  0, 0, 0);
        vecs[1]  = mk(0, 0, 1,  30, 58,  1,    0,  0,  0,  0, 0, 0);
        // Edit 01:58:30 -> 03:57:31
        vecs[2]  = mk(1, 0, 0,  30, 58,  1,   30, 58,  1,  0, 1, 1);
        vecs[3]  = mk(0, 1, 0,  30, 58,  1,   30, 58,  2,  0, 1, 1);
        vecs[4]  = mk(0, 1, 0,  30, 58,  1,   30, 58,  3,  0, 1, 1);
        vecs[5]  = mk(1, 0, 0,  30, 58,  1,   30, 58,  3,  0, 1, 2);
        vecs[6]  = mk(0, 0, 1,  30, 58,  1,   30, 57,  3,  0, 1, 2);
        vecs[7]  = mk(1, 0, 0,  30, 58,  1,   30, 57,  3,  0, 1, 3);
        vecs[8]  = mk(0, 1, 0,  30, 58,  1,   31, 57,  3,  0, 1, 3);
        vecs[9]  = mk(1, 0, 0,  30, 58,  1,   31, 57,  3,  1, 0, 0);
        vecs[10] = mk(0, 0, 0,  30, 58,  1,   31, 57,  3,  0, 0, 0);
        vecs[11] = mk(0, 1, 0,  30, 58,  1,   31, 57,  3,  0, 0, 0);
        // Wrap limits, starting from 23:59:00
        vecs[12] = mk(1, 0, 0,   0, 59, 23,    0, 59, 23,  0, 1, 1);
        vecs[13] = mk(0, 1, 0,   0, 59, 23,    0, 59,  0,  0, 1, 1);
        vecs[14] = mk(0, 0, 1,   0, 59, 23,    0, 59, 23,  0, 1, 1);
        vecs[15] = mk(1, 0, 0,   0, 59, 23,    0, 59, 23,  0, 1, 2);
        vecs[16] = mk(0, 1, 0,   0, 59, 23,    0,  0, 23,  0, 1, 2);
        vecs[17] = mk(0, 0, 1,   0, 59, 23,    0, 59, 23,  0, 1, 2);
        vecs[18] = mk(1, 0, 0,   0, 59, 23,    0, 59, 23,  0, 1, 3);
        vecs[19] = mk(0, 0, 1,   0, 59, 23,   59, 59, 23,  0, 1, 3);
        vecs[20] = mk(0, 1, 0,   0, 59, 23,    0, 59, 23,  0, 1, 3);
        vecs[21] = mk(1, 0, 0,   0, 59, 23,    0, 59, 23,  1, 0, 0);
        vecs[22] = mk(0, 0, 0,   0, 59, 23,    0, 59, 23,  0, 0, 0);
        // Out-of-range capture and button collisions
        vecs[23] = mk(1, 0, 0,  62, 58,  1,    0, 58,  1,  0, 1, 1);
        vecs[24] = mk(0, 1, 1,  62, 58,  1,    0, 58,  1,  0, 1, 1);
        vecs[25] = mk(1, 1, 0,  62, 58,  1,    0, 58,  1,  0, 1, 2);
        vecs[26] = mk(1, 0, 1,  62, 58,  1,    0, 58,  1,  0, 1, 3);
        vecs[27] = mk(0, 1, 1,  62, 58,  1,    0, 58,  1,  0, 1, 3);
        vecs[28] = mk(1, 1, 0,  62, 58,  1,    0, 58,  1,  1, 0, 0);
        vecs[29] = mk(0, 0, 0,  62, 58,  1,    0, 58,  1,  0, 0, 0);
        vecs[30] = mk(1, 0, 0,  45, 63, 31,   45,  0,  0,  0, 1, 1);

        // Reset held two cycles while inc/dec pulse
        step(0, 1, 0);
        check_all("rst0", 0, 0, 0, 0, 0, 0);
        step(0, 0, 1);
        check_all("rst1", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int k = 0; k < 31; k++) begin
            set_cur(int'(vecs[k].hc), int'(vecs[k].mc), int'(vecs[k].sc));
            step(vecs[k].m, vecs[k].i, vecs[k].d);
            check_all($sformatf("vec%0d", k), int'(vecs[k].es), int'(vecs[k].em),
                      int'(vecs[k].eh), int'(vecs[k].eset), int'(vecs[k].eed),
                      int'(vecs[k].ef));
        end

        // Timeout: edit entered by vec30; 15 further idle cycles stay in edit
        for (int k = 1; k <= 15; k++) begin
            step(0, 0, 0);
            check_all($sformatf("to_a%0d", k), 45, 0, 0, 0, 1, 1);
        end
        step(0, 0, 0);
        check_all("to_a_abort", 45, 0, 0, 0, 0, 0);
        step(0, 0, 0);
        check_all("to_a_idle", 45, 0, 0, 0, 0, 0);

        // Timeout restart: press inc on the 10th cycle after entering edit
        set_cur(10, 20, 30);
        step(1, 0, 0);
        check_all("to_b_enter", 30, 20, 10, 0, 1, 1);
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 0);
            check_all($sformatf("to_b%0d", k), 30, 20, 10, 0, 1, 1);
        end
        step(0, 1, 0);
        check_all("to_b_press", 30, 20, 11, 0, 1, 1);
        for (int k = 1; k <= 15; k++) begin
            step(0, 0, 0);
            check_all($sformatf("to_c%0d", k), 30, 20, 11, 0, 1, 1);
        end
        step(0, 0, 0);
        check_all("to_c_abort", 30, 20, 11, 0, 0, 0);

        // Reset while in EDIT_MIN
        set_cur(5, 6, 7);
        step(1, 0, 0);
        step(1, 0, 0);
        check_all("rmin_pre", 7, 6, 5, 0, 1, 2);
        reset = 1'b1;
        step(0, 1, 0);
        check_all("rmin_rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 1, 0);
        check_all("rmin_post", 0, 0, 0, 0, 0, 0);

        // Reset while in COMMIT
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check_all("rcom_pre", 7, 6, 5, 1, 0, 0);
        reset = 1'b1;
        step(1, 0, 0);
        check_all("rcom_rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0);
        check_all("rcom_post", 0, 0, 0, 0, 0, 0);

        // Reset together with the committing mode pulse: no strobe
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check_all("rsec_pre", 7, 6, 5, 0, 1, 3);
        reset = 1'b1;
        step(1, 0, 0);
        check_all("rsec_rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0);
        check_all("rsec_post", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_time_setter
`default_nettype wire
